// File: rtl/mul8_seq_ctrl_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier built around
// a single 4x4 partial-product core.
package mul8_seq_ctrl_pkg;

  localparam int OP_W   = 8;
  localparam int NIB_W  = 4;
  localparam int PROD_W = 16;
  localparam int STEPS  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [1:0] step_t;

  localparam step_t LAST_STEP = 2'd3;

  // Left shift applied to the core result at each step: lo*lo, lo*hi, hi*lo, hi*hi.
  localparam logic [3:0] SHIFT_TBL [STEPS] = '{4'd0, 4'd4, 4'd4, 4'd8};

  // Two-bit step advance written as plain logic so the accumulator adder
  // remains the only arithmetic in the controller.
  function automatic step_t step_next(input step_t s);
    return {s[1] ^ s[0], ~s[0]};
  endfunction

endpackage

// File: rtl/mult4_core.sv
// 4x4 unsigned array multiplier: AND-gate partial products reduced row by row
// with half/full adder cells. Purely combinational.
module mult4_core
  import mul8_seq_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0]   x,
  input  logic [NIB_W-1:0]   y,
  output logic [2*NIB_W-1:0] p
);

  // Each row adds the next partial product to the running upper bits; the
  // lowest bit of every row sum is a finished product bit.
  function automatic logic [2*NIB_W-1:0] array_mul(input logic [NIB_W-1:0] fx,
                                                   input logic [NIB_W-1:0] fy);
    logic [NIB_W-1:0]   row;
    logic [NIB_W-1:0]   sum;
    logic [2*NIB_W-1:0] res;
    logic               c;
    logic               t;
    logic               pp;
    // NOTE: every local is fully assigned before it is read, so nothing here can imply storage.
    res = '0;
    sum = '0;
    for (int j = 0; j < NIB_W; j++) begin
      row[j] = fx[j] & fy[0];
    end
    res[0] = row[0];
    row    = {1'b0, row[NIB_W-1:1]};
    for (int i = 1; i < NIB_W; i++) begin
      c = 1'b0;
      for (int j = 0; j < NIB_W; j++) begin
        pp     = fx[j] & fy[i];
        t      = pp ^ row[j];
        sum[j] = t ^ c;
        c      = (pp & row[j]) | (c & t);
      end
      res[i] = sum[0];
      row    = {c, sum[NIB_W-1:1]};
    end
    res[2*NIB_W-1:NIB_W] = row;
    return res;
  endfunction

  assign p = array_mul(x, y);

endmodule

// File: rtl/mul8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier. Accepted operands are latched and the
// four nibble products are pushed through one mult4_core over four cycles,
// accumulating into a 16-bit register that drives the product output.
// Valid/ready handshake on both sides; one operation in flight at a time.
module mul8_seq_ctrl
  import mul8_seq_ctrl_pkg::*;
#(
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy
);

  state_t              r_state;
  step_t               r_step;
  logic [OP_W-1:0]     r_a;
  logic [OP_W-1:0]     r_b;
  logic [PROD_W-1:0]   r_acc;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;

  logic [NIB_W-1:0]    w_x;
  logic [NIB_W-1:0]    w_y;
  logic [2*NIB_W-1:0]  w_core;
  logic [PROD_W-1:0]   w_shifted;
  logic [PROD_W-1:0]   w_acc_next;
  logic                w_zero_op;

  // Step bit 1 picks the multiplicand nibble, step bit 0 the multiplier nibble.
  assign w_x = r_step[1] ? r_a[OP_W-1:NIB_W] : r_a[NIB_W-1:0];
  assign w_y = r_step[0] ? r_b[OP_W-1:NIB_W] : r_b[NIB_W-1:0];

  mult4_core u_core (
    .x (w_x),
    .y (w_y),
    .p (w_core)
  );

  // Worst case sum is 0xFF*0xFF, so the 16-bit add can never overflow.
  assign w_shifted  = {{(PROD_W-2*NIB_W){1'b0}}, w_core} << SHIFT_TBL[r_step];
  assign w_acc_next = r_acc + w_shifted;
  assign w_zero_op  = (a == '0) || (b == '0);

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
    if (rst) begin
      r_state     <= IDLE;
      r_step      <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= b;
            r_acc      <= '0;
            r_step     <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (ZERO_SKIP && w_zero_op) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= MUL;
            end
          end
        end
        MUL: begin
          r_acc  <= w_acc_next;
          r_step <= step_next(r_step);
          if (r_step == LAST_STEP) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign product   = r_acc;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Directed checks on one ZERO_SKIP=1 instance and one ZERO_SKIP=0 instance,
// then an exhaustive sweep of all operand pairs split across parallel lanes.
module tb_mul8_seq_ctrl;
  import mul8_seq_ctrl_pkg::*;

  localparam int NLANE    = 16;
  localparam int PER_LANE = 65536 / NLANE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int lanes_done = 0;
  int results_seen = 0;
  bit go_exh = 1'b0;

  logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] product;

  logic        nz_rst, nz_in_valid, nz_in_ready, nz_out_valid, nz_out_ready, nz_busy;
  logic [7:0]  nz_a, nz_b;
  logic [15:0] nz_product;

  logic        rst_x;

  mul8_seq_ctrl #(.ZERO_SKIP(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  mul8_seq_ctrl #(.ZERO_SKIP(1'b0)) dut_nz (
    .clk(clk), .rst(nz_rst), .in_valid(nz_in_valid), .in_ready(nz_in_ready),
    .a(nz_a), .b(nz_b), .out_valid(nz_out_valid), .out_ready(nz_out_ready),
    .product(nz_product), .busy(nz_busy)
  );

  // Exhaustive lanes: each owns a DUT and a contiguous slice of {a,b}.
  genvar g;
  for (g = 0; g < NLANE; g++) begin : g_lane
    logic        l_in_valid, l_in_ready, l_out_valid, l_out_ready, l_busy;
    logic [7:0]  l_a, l_b;
    logic [15:0] l_product;

    mul8_seq_ctrl u_dut (
      .clk(clk), .rst(rst_x), .in_valid(l_in_valid), .in_ready(l_in_ready),
      .a(l_a), .b(l_b), .out_valid(l_out_valid), .out_ready(l_out_ready),
      .product(l_product), .busy(l_busy)
    );

    initial begin
      logic [15:0] pair;
      logic [15:0] expv;
      int          w;
      bit          taken;
      int          got;
      l_in_valid  = 1'b0;
      l_out_ready = 1'b0;
      l_a = 8'h00;
      l_b = 8'h00;
      got = 0;
      wait (go_exh == 1'b1);
      @(negedge clk);
      for (int p = 0; p < PER_LANE; p++) begin
        pair = 16'(g * PER_LANE + p);
        l_a  = pair[15:8];
        l_b  = pair[7:0];
        expv = {8'h00, l_a} * {8'h00, l_b};
        l_in_valid = 1'b1;
        w = 0;
        while (l_in_ready !== 1'b1 && w < 20) begin
          @(negedge clk);
          w++;
        end
        total++;
        if (l_in_ready !== 1'b1 || l_out_valid !== 1'b0) begin
          bad++;
          $display("FAIL lane%0d_accept a=%h b=%h: in_ready=%b out_valid=%b, want 1 and 0",
                   g, l_a, l_b, l_in_ready, l_out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        l_in_valid = 1'b0;
        w = 0;
        taken = 1'b0;
        while (!taken && w < 40) begin
          if (l_out_valid === 1'b1 && $urandom_range(0, 3) != 0) begin
            l_out_ready = 1'b1;
            taken = 1'b1;
            got++;
            total++;
            if (l_product !== expv || l_busy !== 1'b1) begin
              bad++;
              $display("FAIL lane%0d_product a=%h b=%h: got %h busy=%b, want %h busy=1",
                       g, l_a, l_b, l_product, l_busy, expv);
            end
          end else begin
            l_out_ready = 1'b0;
            @(negedge clk);
            w++;
          end
        end
        total++;
        if (!taken) begin
          bad++;
          $display("FAIL lane%0d_timeout a=%h b=%h: no out_valid within 40 cycles", g, l_a, l_b);
        end
        @(negedge clk);
        l_out_ready = 1'b0;
      end
      results_seen += got;
      lanes_done++;
    end
  end

  // Present operands at the current negedge, let the next edge accept them,
  // then wait (bounded) for out_valid. lat counts cycles after acceptance.
  task automatic start_op(input bit nz, input logic [7:0] ta, input logic [7:0] tbv,
                          output int lat, output bit busy_all);
    if (nz) begin
      nz_a = ta; nz_b = tbv; nz_in_valid = 1'b1;
    end else begin
      a = ta; b = tbv; in_valid = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid    = 1'b0;
    nz_in_valid = 1'b0;
    lat = 1;
    busy_all = 1'b1;
    while ((nz ? nz_out_valid : out_valid) !== 1'b1 && lat < 20) begin
      if ((nz ? nz_busy : busy) !== 1'b1) busy_all = 1'b0;
      @(negedge clk);
      lat++;
    end
    if ((nz ? nz_busy : busy) !== 1'b1) busy_all = 1'b0;
  endtask

  task automatic consume(input bit nz);
    if (nz) nz_out_ready = 1'b1; else out_ready = 1'b1;
    @(negedge clk);
    nz_out_ready = 1'b0;
    out_ready    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; nz_rst = 1'b1; rst_x = 1'b1;
    in_valid = 1'b0; a = 8'h00; b = 8'h00; out_ready = 1'b0;
    nz_in_valid = 1'b0; nz_a = 8'h00; nz_b = 8'h00; nz_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (product !== 16'h0000) begin bad++; $display("FAIL reset_product: got %h want 0000", product); end
    total++; if (nz_in_ready !== 1'b1 || nz_busy !== 1'b0) begin bad++; $display("FAIL reset_nz: in_ready=%b busy=%b want 1/0", nz_in_ready, nz_busy); end
    rst = 1'b0; nz_rst = 1'b0; rst_x = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || dut.r_state !== IDLE) begin bad++; $display("FAIL reset_release: in_ready=%b state=%0d want 1/IDLE", in_ready, dut.r_state); end
  endtask

  task automatic test_full_scale();
    int lat;
    bit ball;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ff_in_ready_before: got %b want 1", in_ready); end
    start_op(1'b0, 8'hFF, 8'hFF, lat, ball);
    total++; if (lat != 5) begin bad++; $display("FAIL ff_latency: got %0d want 5", lat); end
    total++; if (!ball) begin bad++; $display("FAIL ff_busy: busy dropped during T+1..T+5, want high"); end
    total++; if (product !== 16'hFE01) begin bad++; $display("FAIL ff_product: got %h want fe01", product); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ff_in_ready_done: got %b want 0", in_ready); end
    consume(1'b0);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ff_after: in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy); end
  endtask

  task automatic test_backpressure();
    int lat;
    bit ball;
    start_op(1'b0, 8'h12, 8'h34, lat, ball);
    total++; if (lat != 5) begin bad++; $display("FAIL bp_latency: got %0d want 5", lat); end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (out_valid !== 1'b1 || product !== 16'h03A8 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: out_valid=%b product=%h in_ready=%b want 1/03a8/0", k, out_valid, product, in_ready);
      end
      @(negedge clk);
    end
    total++; if (out_valid !== 1'b1 || product !== 16'h03A8) begin bad++; $display("FAIL bp_release: out_valid=%b product=%h want 1/03a8", out_valid, product); end
    consume(1'b0);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || dut.r_state !== IDLE) begin bad++; $display("FAIL bp_idle: in_ready=%b out_valid=%b state=%0d want 1/0/IDLE", in_ready, out_valid, dut.r_state); end
  endtask

  task automatic test_zero_skip();
    int lat;
    bit ball;
    start_op(1'b0, 8'h00, 8'hAB, lat, ball);
    total++; if (lat != 1) begin bad++; $display("FAIL zs_a0_latency: got %0d want 1", lat); end
    total++; if (product !== 16'h0000) begin bad++; $display("FAIL zs_a0_product: got %h want 0000", product); end
    consume(1'b0);
    start_op(1'b0, 8'h37, 8'h00, lat, ball);
    total++; if (lat != 1 || product !== 16'h0000) begin bad++; $display("FAIL zs_b0: latency=%0d product=%h want 1/0000", lat, product); end
    consume(1'b0);
    start_op(1'b1, 8'h00, 8'hAB, lat, ball);
    total++; if (lat != 5) begin bad++; $display("FAIL nz_latency: got %0d want 5", lat); end
    total++; if (nz_product !== 16'h0000 || !ball) begin bad++; $display("FAIL nz_product: got %h busy_ok=%b want 0000/1", nz_product, ball); end
    consume(1'b1);
    total++; if (nz_in_ready !== 1'b1 || nz_out_valid !== 1'b0) begin bad++; $display("FAIL nz_after: in_ready=%b out_valid=%b want 1/0", nz_in_ready, nz_out_valid); end
  endtask

  task automatic test_ignore_busy();
    int lat;
    a = 8'h0F; b = 8'h11; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 8'h55; b = 8'h55;
    @(negedge clk);
    total++; if (in_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL ib_in_ready: in_ready=%b busy=%b want 0/1", in_ready, busy); end
    total++; if (dut.r_a !== 8'h0F || dut.r_b !== 8'h11) begin bad++; $display("FAIL ib_latched: a=%h b=%h want 0f/11", dut.r_a, dut.r_b); end
    lat = 2;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    total++; if (lat != 5) begin bad++; $display("FAIL ib_latency: got %0d want 5", lat); end
    total++; if (product !== 16'h00FF) begin bad++; $display("FAIL ib_product: got %h want 00ff", product); end
    consume(1'b0);
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL ib_no_extra_op: out_valid=%b busy=%b in_ready=%b want 0/0/1", out_valid, busy, in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit ball;
    bit seen;
    a = 8'h9C; b = 8'h3E; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (dut.r_step !== 2'd2 || dut.r_state !== MUL) begin bad++; $display("FAIL rm_step: step=%0d state=%0d want 2/MUL", dut.r_step, dut.r_state); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (dut.r_state !== IDLE || out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rm_idle: state=%0d out_valid=%b busy=%b want IDLE/0/0", dut.r_state, out_valid, busy); end
    total++; if (product !== 16'h0000 || in_ready !== 1'b1) begin bad++; $display("FAIL rm_clear: acc=%h in_ready=%b want 0000/1", product, in_ready); end
    total++; if (dut.r_a !== 8'h00 || dut.r_b !== 8'h00 || dut.r_step !== 2'd0) begin bad++; $display("FAIL rm_regs: a=%h b=%h step=%0d want 00/00/0", dut.r_a, dut.r_b, dut.r_step); end
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    total++; if (seen) begin bad++; $display("FAIL rm_no_pulse: out_valid rose after reset, want 0"); end
    start_op(1'b0, 8'h03, 8'h05, lat, ball);
    total++; if (lat != 5 || product !== 16'h000F) begin bad++; $display("FAIL rm_next: latency=%0d product=%h want 5/000f", lat, product); end
    consume(1'b0);
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_backpressure();
    test_zero_skip();
    test_ignore_busy();
    test_reset_mid();
    go_exh = 1'b1;
    for (int c = 0; c < 80000 && lanes_done < NLANE; c++) @(negedge clk);
    total++; if (lanes_done != NLANE) begin bad++; $display("FAIL exh_lanes: finished %0d want %0d", lanes_done, NLANE); end
    total++; if (results_seen != 65536) begin bad++; $display("FAIL exh_count: results %0d want 65536", results_seen); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul8_seq_ctrl.md
MUL8_SEQ_CTRL -- requirements
Module: mul8_seq_ctrl

Interface
REQ-001 The block SHALL have parameter ZERO_SKIP, default 1: when 1, a zero operand completes without using the core.
REQ-002 The block SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 The block SHALL have port rst, input, 1: synchronous, active-high reset (one clock; reset is synchronous and active-high).
REQ-004 The block SHALL have port in_valid, input, 1: operand pair offered.
REQ-005 The block SHALL have port in_ready, output, 1: block accepts operands this cycle.
REQ-006 The block SHALL have port a, input, 8: unsigned multiplicand.
REQ-007 The block SHALL have port b, input, 8: unsigned multiplier.
REQ-008 The block SHALL have port out_valid, output, 1: product available.
REQ-009 The block SHALL have port out_ready, input, 1: consumer takes product this cycle.
REQ-010 The block SHALL have port product, output, 16: a*b, unsigned.
REQ-011 The block SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-012 The block SHALL compute an 8x8 unsigned product by sequencing four 4x4 partial products through a single 4x4 multiplier core.
REQ-013 FSM states SHALL be IDLE, MUL and DONE; the step counter SHALL be 2 bits (0..3).
REQ-014 in_ready SHALL equal 1 in IDLE only; acceptance SHALL be the cycle in which in_valid and in_ready are both 1.
REQ-015 On acceptance, a and b SHALL be latched, the 16-bit accumulator cleared, step set to 0, and the FSM moved to MUL.
REQ-016 In MUL, step k SHALL feed the core the nibble pairs (a[3:0],b[3:0]), (a[3:0],b[7:4]), (a[7:4],b[3:0]), (a[7:4],b[7:4]) and add the 8-bit core result shifted left by 0, 4, 4 and 8 bits respectively into the accumulator.
REQ-017 Accumulator additions SHALL be 16-bit, with no overflow possible; the core result SHALL be combinational and registered only in the accumulator.
REQ-018 After step 3 the FSM SHALL enter DONE, so that with acceptance at cycle T, out_valid rises at T+5.
REQ-019 In DONE, out_valid SHALL be 1 and product SHALL equal the accumulator; product SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 In DONE with out_ready=1, the FSM SHALL return to IDLE next cycle; in_ready SHALL NOT be asserted in that same cycle (no overlap).
REQ-021 With ZERO_SKIP=1 and a==0 or b==0 at acceptance, the FSM SHALL go directly to DONE with product 0, giving out_valid at T+1.
REQ-022 With ZERO_SKIP=0, zero operands SHALL take the normal 4-step path.
REQ-023 in_valid and the a/b inputs SHALL be ignored outside IDLE; the latched operands SHALL NOT change mid-operation.
REQ-024 out_valid SHALL be 0 in IDLE and MUL.

Reset
REQ-025 On rst=1 at a clock edge, from any state including mid-MUL or DONE, the FSM SHALL go to IDLE, the step counter, accumulator, latched operands, out_valid and busy SHALL go to 0, and in_ready SHALL go to 1 in the following cycle.
REQ-026 An operation interrupted by reset SHALL be discarded, with no out_valid pulse.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (IDLE/MUL/DONE), the nibble shift-amount constant table {0,4,4,8}, and the widths OP_W=8, NIB_W=4 and PROD_W=16.
REQ-028 The block SHALL instantiate exactly one sub-module, mult4_core: the team's 4-bit partial-product/HA-FA reduction multiplier, with 4-bit x and y inputs and an 8-bit output.
REQ-029 The block SHALL contain no other arithmetic instances beyond the accumulator adder.

Verification
REQ-030 The bench SHALL cover: a=0xFF, b=0xFF accepted at T -> out_valid at T+5, product=0xFE01, busy high for T+1..T+5.
REQ-031 The bench SHALL cover: a=0x12, b=0x34 with out_ready held 0 for 3 cycles -> product=0x03A8 held stable with out_valid=1; IDLE and in_ready=1 on the cycle after out_ready=1.
REQ-032 The bench SHALL cover: ZERO_SKIP=1, a=0x00, b=0xAB -> out_valid at T+1, product=0x0000; with ZERO_SKIP=0 -> out_valid at T+5, product=0x0000.
REQ-033 The bench SHALL cover: in_valid=1 with a=0x55 while busy -> ignored; the current result is unchanged and in_ready=0.
REQ-034 The bench SHALL cover: rst pulsed at step 2 of 0x9C*0x3E -> next cycle IDLE, out_valid=0, accumulator=0; a following 0x03*0x05 returns 0x000F.
REQ-035 The bench SHALL run exhaustive 65536 operand pairs with random out_ready backpressure, each result checked against a*b, with no lost or duplicated outputs.
